// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream beat in, downstream beat out,
// plus flush and an occupancy readout. Signal names carry the direction seen by the stage.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  flush_i;
    logic                  up_valid_i;
    logic                  up_ready_o;
    logic [DATA_WIDTH-1:0] up_data_i;
    logic                  dn_valid_o;
    logic                  dn_ready_i;
    logic [DATA_WIDTH-1:0] dn_data_o;
    logic [1:0]            occupancy_o;

    // Environment side: drives beats in, consumes beats out.
    modport master (
        output flush_i,
        output up_valid_i,
        output up_data_i,
        output dn_ready_i,
        input  up_ready_o,
        input  dn_valid_o,
        input  dn_data_o,
        input  occupancy_o
    );

    // Stage side.
    modport slave (
        input  flush_i,
        input  up_valid_i,
        input  up_data_i,
        input  dn_ready_i,
        output up_ready_o,
        output dn_valid_o,
        output dn_data_o,
        output occupancy_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and optional skid entry.
// SKID=1: main + skid entry, full throughput, up_ready_o comes straight from a flop.
// SKID=0: single entry, up_ready_o combinational from dn_ready_i.
module pipe_stage_reg #(
    parameter int unsigned   DATA_WIDTH = 64,
    parameter bit            SKID       = 1'b1,
    parameter logic [1023:0] RESET_DATA = '0
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);

    // Encoding keeps dn_valid a direct state bit.
    typedef enum logic [1:0] {
        StEmpty    = 2'b00,
        StFull     = 2'b01,
        StSkidFull = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  load_main;
    logic                  load_skid;
    logic                  main_from_skid;
    logic                  up_ready_d;
    logic                  up_ready;
    logic                  dn_valid;
    logic [1:0]            occupancy;

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and entry-load strobes; flush empties the stage and drops the offered beat.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (bus.up_valid_i) begin
                        state_d   = StFull;
                        load_main = 1'b1;
                    end
                end
                StFull: begin
                    if (bus.up_valid_i && bus.dn_ready_i) begin
                        load_main = 1'b1;
                    end else if (bus.up_valid_i && SKID) begin
                        // Downstream stalled: park the new beat behind the main one.
                        state_d   = StSkidFull;
                        load_skid = 1'b1;
                    end else if (bus.dn_ready_i) begin
                        state_d = StEmpty;
                    end
                end
                StSkidFull: begin
                    if (bus.dn_ready_i) begin
                        state_d        = StFull;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
        up_ready_d = (state_d != StSkidFull);
    end

    // Main entry: only updated by accepted or promoted beats, so it holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= RESET_DATA[DATA_WIDTH-1:0];
        end else if (load_main) begin
            main_q <= bus.up_data_i;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
    end

    if (SKID) begin : g_skid
        // Skid data needs no reset; its validity is carried by the state.
        always_ff @(posedge clk) begin
            if (load_skid) begin
                skid_q <= bus.up_data_i;
            end
        end

        logic up_ready_q;

        // Registered ready so no combinational path crosses stages.
        always_ff @(posedge clk) begin
            if (rst) begin
                up_ready_q <= 1'b1;
            end else begin
                up_ready_q <= up_ready_d;
            end
        end

        assign up_ready = up_ready_q;
    end else begin : g_single
        assign skid_q   = '0;
        assign up_ready = ~dn_valid | bus.dn_ready_i;
    end

    // Outputs decoded from state.
    always_comb begin
        dn_valid  = state_q[0];
        occupancy = 2'd0;
        unique case (state_q)
            StFull:     occupancy = 2'd1;
            StSkidFull: occupancy = 2'd2;
            default:    occupancy = 2'd0;
        endcase
    end

    assign bus.up_ready_o  = up_ready;
    assign bus.dn_valid_o  = dn_valid;
    assign bus.dn_data_o   = main_q;
    assign bus.occupancy_o = occupancy;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, flush and an optional skid entry. It replaces the fixed-field, stall-only inter-stage registers of the core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Callers pack stage fields into one data bus. With `SKID=1`, `up_ready_o` is a pure register output, so there is no combinational ready path between stages.

## Interface
- `DATA_WIDTH`, 64: width of the packed stage payload; legal range 1..1024.
- `SKID`, 1: 0 = single entry with combinational ready path; 1 = main + skid entry with full throughput and registered ready.
- `RESET_DATA`, 0: value loaded into `dn_data_o` on reset, zero-extended or truncated to `DATA_WIDTH`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  discard all held beats and any beat offered this cycle.
- `up_valid_i`  in  1  upstream beat valid.
- `up_ready_o`  out  1  stage can accept a beat this cycle.
- `up_data_i`  in  DATA_WIDTH  upstream payload.
- `dn_valid_o`  out  1  downstream beat valid (registered).
- `dn_ready_i`  in  1  downstream accepts this cycle.
- `dn_data_o`  out  DATA_WIDTH  downstream payload (registered).
- `occupancy_o`  out  2  number of beats held: 0, 1 or 2.

## Operation
- A beat transfers on a port when valid and ready are both 1 at a rising edge.
- States: EMPTY (occ 0), FULL (main entry holds a beat, occ 1), SKID_FULL (main and skid entries hold beats, occ 2; `SKID=1` only).
- Priority at each edge: `rst` first, then `flush_i`, then the handshake.
- `SKID=1`: `up_ready_o = (state != SKID_FULL)`. This is registered and has no dependence on `dn_ready_i`.
  - EMPTY: if `up_valid_i`, go to FULL and load main from `up_data_i`.
  - FULL: if `up_valid_i` & `dn_ready_i`, stay in FULL and reload main from `up_data_i`. If `up_valid_i` & !`dn_ready_i`, go to SKID_FULL and load skid from `up_data_i`. If !`up_valid_i` & `dn_ready_i`, go to EMPTY. Otherwise hold.
  - SKID_FULL: if `dn_ready_i`, go to FULL, main <= skid. Otherwise hold.
- `SKID=0`: `up_ready_o = !dn_valid_o | dn_ready_i` (combinational). SKID_FULL is unreachable and the skid register is not built.
- `dn_valid_o` = (state != EMPTY). `dn_data_o` = main entry.
- Order is preserved: the skid beat always drains after the main beat.
- Flush: the next state is EMPTY, `occupancy_o` becomes 0, and the upstream beat in the flush cycle is dropped even if `up_ready_o` = 1. Data registers keep their values; only the valids clear.
- `dn_data_o` holds its last value while `dn_valid_o` = 0. It does not update on dropped or flushed beats.

## Timing
- Reset edge: `dn_valid_o` = 0, `dn_data_o` = `RESET_DATA`, `occupancy_o` = 0, skid valid = 0. `up_ready_o` = 1 from the first cycle after the reset edge. A beat offered during a `rst` cycle is dropped.
- Reset or flush asserted mid-transfer (state FULL or SKID_FULL): all held beats are lost. The next cycle is EMPTY with `up_ready_o` = 1.
- Latency: a beat accepted at edge N appears on `dn_*` in the cycle after edge N (1 cycle).
- Throughput: 1 beat per cycle in steady state for both SKID values. With `SKID=1`, downstream stalls of any length lose no beat.
- Stability: while `dn_valid_o` & !`dn_ready_i`, `dn_data_o` and `dn_valid_o` are held unchanged.
- `up_ready_o` (`SKID=1`) falls exactly in the cycle after the edge that fills skid. It rises in the cycle after the edge where `dn_ready_i` drains main.
- Simultaneous accept and drain in FULL leaves occupancy at 1, with no bubble.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `up_valid_i` = 1 and data 0xAA -> after release, `dn_valid_o` = 0, `dn_data_o` = `RESET_DATA`, `occupancy_o` = 0, `up_ready_o` = 1.
- Streaming, `SKID=1`, `dn_ready_i` = 1: send beats 1..8 back to back -> 1..8 emerge in order on consecutive cycles, each 1 cycle after its accept. `occupancy_o` stays at 1.
- Backpressure, `SKID=1`: hold `dn_ready_i` = 0 while sending beats A, B, C -> A and B are accepted, `occupancy_o` = 2, `up_ready_o` = 0, and C stays pending. Release `dn_ready_i` -> A, B, C are delivered in order with no loss and no duplicate.
- Flush in SKID_FULL with a new beat D offered: assert `flush_i` for 1 cycle -> next cycle `dn_valid_o` = 0, `occupancy_o` = 0, and D never appears downstream.
- `SKID=0`: with `dn_valid_o` = 1 and `dn_ready_i` = 0, `up_ready_o` = 0 in the same cycle. When `dn_ready_i` rises, `up_ready_o` = 1 in that same cycle and the new beat replaces the old one at the next edge.
- Random valid/ready over 10k cycles at `DATA_WIDTH` = 1 and 97 -> a scoreboard sees exact in-order delivery, and `dn_data_o` is stable whenever `dn_valid_o` & !`dn_ready_i`.
